// File: rtl/acc_mul_seq.sv
// Shift-and-add multiply sequencer driving the AH/AL accumulator pair and ALU.
// Control outputs are decoded from state; in EVAL they also follow al_lsb.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_LDM   | AH <= multiplier (ah_in), B <= multiplicand
//   S_XFR   | AL <= AH
//   S_CLR   | clear AH, counter and carry
//   S_EVAL  | multiplier bit 1: AH <= AH+B; bit 0: shift AH:AL right
//   S_SHIFT | shift AH:AL right with ALU carry into AH msb
//   S_DONE  | product valid in AH:AL
module acc_mul_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       start,
    input  logic       abort,
    input  logic       al_lsb,
    input  logic       alu_cout,
    output logic       b_we,
    output logic       ah_inen,
    output logic       ah_reset,
    output logic       en,
    output logic [1:0] hs,
    output logic [1:0] ls,
    output logic       carry_out,
    output logic       alu_add,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDM,
        S_XFR,
        S_CLR,
        S_EVAL,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cy;
    logic             w_last;

    assign w_last    = (r_cnt == LP_LAST);
    assign carry_out = r_cy;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cy    <= 1'b0;
        end else if (abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) r_state <= S_LDM;
                S_LDM:   r_state <= S_XFR;
                S_XFR:   r_state <= S_CLR;
                S_CLR: begin
                    r_cnt   <= '0;
                    r_cy    <= 1'b0;
                    r_state <= S_EVAL;
                end
                S_EVAL: begin
                    if (al_lsb) begin
                        r_cy    <= alu_cout;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cy    <= 1'b0;
                        r_cnt   <= r_cnt + LP_ONE;
                        r_state <= w_last ? S_DONE : S_EVAL;
                    end
                end
                S_SHIFT: begin
                    r_cy    <= 1'b0;
                    r_cnt   <= r_cnt + LP_ONE;
                    r_state <= w_last ? S_DONE : S_EVAL;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        b_we     = 1'b0;
        ah_inen  = 1'b0;
        ah_reset = 1'b0;
        en       = 1'b0;
        hs       = 2'b00;
        ls       = 2'b00;
        alu_add  = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            S_IDLE: busy = 1'b0;
            S_LDM: begin
                ah_inen = 1'b1;
                hs      = 2'b11;
                en      = 1'b1;
                b_we    = 1'b1;
            end
            S_XFR:  ls = 2'b11;
            S_CLR:  ah_reset = 1'b1;
            S_EVAL: begin
                en = 1'b1;
                if (al_lsb) begin
                    alu_add = 1'b1;
                    hs      = 2'b11;
                end else begin
                    hs = 2'b01;
                    ls = 2'b01;
                end
            end
            S_SHIFT: begin
                hs = 2'b01;
                ls = 2'b01;
                en = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_acc_mul_seq.sv
// Bench for acc_mul_seq: a behavioural AH/AL/B/ALU datapath closes the loop,
// products are compared with a*b and busy length with 3+W+popcount(a)+1.
module tb_acc_mul_seq;

    logic       clk = 1'b0;
    logic       clr_n, start, abort, al_lsb, alu_cout;
    logic       b_we, ah_inen, ah_reset, en, carry_out, alu_add, busy, done;
    logic [1:0] hs, ls;

    logic [3:0] ah_in, b_bus;
    logic [3:0] m_ah, m_al, m_b;
    logic [4:0] w_sum;

    int n_checks = 0;
    int n_fail   = 0;

    int         n_done = 0;
    int         bcnt = 0;
    bit         add_seen = 0, cy_seen = 0, prev_done = 0;
    logic [7:0] last_prod;
    int         last_blen;
    bit         last_add, last_cy;
    logic [7:0] prod_q[$];
    int         blen_q[$];

    acc_mul_seq #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .abort(abort),
        .al_lsb(al_lsb), .alu_cout(alu_cout),
        .b_we(b_we), .ah_inen(ah_inen), .ah_reset(ah_reset), .en(en),
        .hs(hs), .ls(ls), .carry_out(carry_out), .alu_add(alu_add),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // accumulator datapath driven by the sequencer's control pins
    assign w_sum    = {1'b0, m_ah} + {1'b0, m_b};
    assign alu_cout = w_sum[4];
    assign al_lsb   = m_al[0];

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_ah <= '0;
            m_al <= '0;
        end else begin
            if (b_we) m_b <= b_bus;
            if (ah_reset) m_ah <= '0;
            else if (en) begin
                case (hs)
                    2'b11: m_ah <= ah_inen ? ah_in : (alu_add ? w_sum[3:0] : m_ah);
                    2'b01: m_ah <= {carry_out, m_ah[3:1]};
                    2'b10: m_ah <= {m_ah[2:0], 1'b0};
                    default: ;
                endcase
            end
            case (ls)
                2'b11: m_al <= m_ah;
                2'b01: m_al <= {m_ah[0], m_al[3:1]};
                2'b10: m_al <= {m_al[2:0], 1'b0};
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (clr_n && prev_done) begin
            chk("done_one_cycle", done, 1'b0);
            chk("idle_after_done", busy, 1'b0);
        end
        prev_done = clr_n && done;
        if (clr_n && busy) begin
            bcnt++;
            if (alu_add) add_seen = 1;
            if (carry_out && hs == 2'b01) cy_seen = 1;
            if (done) begin
                last_prod = {m_ah, m_al};
                last_blen = bcnt;
                last_add  = add_seen;
                last_cy   = cy_seen;
                prod_q.push_back(last_prod);
                blen_q.push_back(bcnt);
                n_done++;
            end
        end else begin
            bcnt = 0;
            add_seen = 0;
            cy_seen = 0;
        end
    end

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input bit pulse);
        int nd;
        int t;
        logic [7:0] exp_p;
        ah_in = a;
        b_bus = b;
        nd = n_done;
        exp_p = 8'(a) * 8'(b);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t = 0;
        while (n_done == nd && t < 40) begin
            @(posedge clk); #1;
            t++;
            start = (pulse && t == 3);
        end
        start = 1'b0;
        if (n_done == nd) chk("op_timeout", 0, 1);
        else begin
            chk("product", last_prod, exp_p);
            chk("busy_len", last_blen, 8 + $countones(a));
            chk("add_used", last_add, a != 0);
        end
    endtask

    initial begin
        int nd;
        int t;
        clr_n = 1'b0; start = 1'b0; abort = 1'b0; ah_in = '0; b_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {b_we, ah_inen, ah_reset, en, hs, ls, carry_out, alu_add, busy, done}, 12'h000);
        clr_n = 1'b1;
        repeat (2) @(posedge clk);

        // async reset while in EVAL, then a clean restart
        ah_in = 4'd6; b_bus = 4'd5;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #3 clr_n = 1'b0;
        #1;
        chk("rst_hs_ls_en", {hs, ls, en}, 5'b0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk); #1 clr_n = 1'b1;
        repeat (2) @(posedge clk);
        do_op(4'd6, 4'd5, 0);

        do_op(4'd5, 4'd3, 0);
        do_op(4'd15, 4'd15, 0);
        chk("carry_in_shift", last_cy, 1'b1);
        do_op(4'd0, 4'd9, 0);

        // abort in the second EVAL of 7x7
        ah_in = 4'd7; b_bus = 4'd7;
        nd = n_done;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        repeat (15) @(posedge clk);
        #1 chk("abort_no_done", n_done, nd);
        do_op(4'd2, 4'd6, 0);

        // start and abort together in IDLE
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", busy, 1'b0);

        // start held high: back-to-back operations
        ah_in = 4'd3; b_bus = 4'd4;
        nd = n_done;
        @(posedge clk); #1 start = 1'b1;
        repeat (30) @(posedge clk);
        #1 start = 1'b0;
        t = 0;
        while (busy && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("b2b_count", n_done - nd, 3);
        for (int i = nd; i < n_done && i < prod_q.size(); i++) begin
            chk("b2b_product", prod_q[i], 8'd12);
            chk("b2b_busy_len", blen_q[i], 10);
        end

        for (int i = 0; i < 20; i++)
            do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
